// File: rtl/hsv_centroid_pkg.sv
// Shared constants, FSM state type and saturating-add helper for the HSV centroid tracker.
package hsv_centroid_pkg;

    localparam int SUM_W     = 30;
    localparam int CNT_W     = 19;
    localparam int DIV_ITERS = 30;
    localparam int ITER_W    = 5;

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_DIV_X   = 2'd1,
        ST_DIV_Y   = 2'd2,
        ST_PUBLISH = 2'd3
    } state_e;

    // Adds two sums and pins the result at all-ones instead of wrapping.
    function automatic logic [SUM_W-1:0] sat_add_sum(input logic [SUM_W-1:0] a,
                                                     input logic [SUM_W-1:0] b);
        logic [SUM_W:0] t;
        t = {1'b0, a} + {1'b0, b};
        return t[SUM_W] ? '1 : t[SUM_W-1:0];
    endfunction

endpackage

// File: rtl/hsv_centroid_if.sv
// Divider request/response bus between the centroid FSM and the shared divider.
//
// Handshake: start is a request that the divider accepts only while busy is 0,
// latching dividend/divisor in that cycle. done is high for exactly one cycle,
// the final iteration cycle; quotient is valid in that same cycle and is
// captured by the requester on that clock edge.
interface hsv_centroid_if import hsv_centroid_pkg::*; #(
    parameter int COORD_W = 10
) ();
    logic               start;
    logic [SUM_W-1:0]   dividend;
    logic [CNT_W-1:0]   divisor;
    logic               busy;
    logic               done;
    logic [COORD_W-1:0] quotient;

    modport master (output start, dividend, divisor, input busy, done, quotient);
    modport slave  (input start, dividend, divisor, output busy, done, quotient);
endinterface

// File: rtl/hsv_centroid_div.sv
// Unsigned restoring divider: one load cycle, then one quotient bit per cycle.
module centroid_div import hsv_centroid_pkg::*; #(
    parameter int COORD_W = 10
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    hsv_centroid_if.slave div
);

    logic               busy_q, busy_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [SUM_W-1:0]   quo_q, quo_d;
    logic [CNT_W-1:0]   dvsr_q, dvsr_d;
    logic [CNT_W:0]     shifted;

    // Load on start, otherwise shift in the next dividend bit and try a subtract.
    always_comb begin
        busy_d  = busy_q;
        iter_d  = iter_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        shifted = {rem_q, quo_q[SUM_W-1]};
        if (!busy_q) begin
            if (div.start) begin
                busy_d = 1'b1;
                iter_d = ITER_W'(DIV_ITERS);
                rem_d  = '0;
                quo_d  = div.dividend;
                dvsr_d = div.divisor;
            end
        end else begin
            if (shifted >= {1'b0, dvsr_q}) begin
                rem_d = shifted[CNT_W-1:0] - dvsr_q;
                quo_d = {quo_q[SUM_W-2:0], 1'b1};
            end else begin
                rem_d = shifted[CNT_W-1:0];
                quo_d = {quo_q[SUM_W-2:0], 1'b0};
            end
            iter_d = iter_q - ITER_W'(1);
            if (iter_q == ITER_W'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    // The mean never exceeds the largest coordinate, so truncation loses nothing.
    assign div.busy     = busy_q;
    assign div.done     = busy_q && (iter_q == ITER_W'(1));
    assign div.quotient = quo_d[COORD_W-1:0];

    // Divider state; reset aborts any divide in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_q <= 1'b0;
            iter_q <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
        end else begin
            busy_q <= busy_d;
            iter_q <= iter_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvsr_q <= dvsr_d;
        end
    end

endmodule

// File: rtl/hsv_centroid.sv
// HSV colour-window matcher with per-frame centroid of matched pixels.
module hsv_centroid import hsv_centroid_pkg::*; #(
    parameter int COORD_W    = 10,
    parameter int MIN_PIXELS = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         h,
    input  logic [7:0]         s,
    input  logic [7:0]         v,
    input  logic               hue_valid,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               frame_end,
    input  logic [7:0]         h_lo,
    input  logic [7:0]         h_hi,
    input  logic [7:0]         s_min,
    input  logic [7:0]         v_min,
    output logic               mask,
    output logic               mask_valid,
    output logic [COORD_W-1:0] cx,
    output logic [COORD_W-1:0] cy,
    output logic [CNT_W-1:0]   pixel_count,
    output logic               found,
    output logic               result_valid,
    output logic               overrun,
    output logic [1:0]         state_dbg
);

    hsv_centroid_if #(.COORD_W(COORD_W)) div_bus ();

    centroid_div #(.COORD_W(COORD_W)) u_div (
        .clk_i  (clock),
        .rst_ni (reset),
        .div    (div_bus.slave)
    );

    state_e             state_q, state_d;
    logic [SUM_W-1:0]   sum_x_q, sum_x_d, sum_y_q, sum_y_d, sum_x_inc, sum_y_inc;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [SUM_W-1:0]   snap_x_q, snap_x_d, snap_y_q, snap_y_d;
    logic [CNT_W-1:0]   snap_cnt_q, snap_cnt_d;
    logic [COORD_W-1:0] xq_q, xq_d, yq_q, yq_d;
    logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [CNT_W-1:0]   pcnt_q, pcnt_d;
    logic               found_q, found_d, rv_q, rv_d, ovr_q, ovr_d;
    logic               mask_q, mask_valid_q;
    logic               hue_ok, hit;

    // A low-to-high window is a plain range; a high-to-low window wraps through 0.
    assign hue_ok = (h_lo <= h_hi) ? ((h >= h_lo) && (h <= h_hi))
                                   : ((h >= h_lo) || (h <= h_hi));
    assign hit    = hue_valid && hue_ok && (s >= s_min) && (v >= v_min);

    // Accumulator values including this cycle's pixel, so a pixel on frame_end joins the closing frame.
    assign sum_x_inc = hit ? sat_add_sum(sum_x_q, SUM_W'(x)) : sum_x_q;
    assign sum_y_inc = hit ? sat_add_sum(sum_y_q, SUM_W'(y)) : sum_y_q;
    assign cnt_inc   = (hit && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    assign div_bus.start    = ((state_q == ST_DIV_X) || (state_q == ST_DIV_Y)) && !div_bus.busy;
    assign div_bus.dividend = (state_q == ST_DIV_Y) ? snap_y_q : snap_x_q;
    assign div_bus.divisor  = snap_cnt_q;

    // Frame sequencing: snapshot on frame_end, divide X then Y, publish; accumulation never pauses.
    always_comb begin
        state_d    = state_q;
        snap_x_d   = snap_x_q;
        snap_y_d   = snap_y_q;
        snap_cnt_d = snap_cnt_q;
        xq_d       = xq_q;
        yq_d       = yq_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        pcnt_d     = pcnt_q;
        found_d    = found_q;
        rv_d       = 1'b0;
        ovr_d      = frame_end && (state_q != ST_ACCUM);
        sum_x_d    = frame_end ? '0 : sum_x_inc;
        sum_y_d    = frame_end ? '0 : sum_y_inc;
        cnt_d      = frame_end ? '0 : cnt_inc;
        case (state_q)
            ST_ACCUM: begin
                if (frame_end) begin
                    snap_x_d   = sum_x_inc;
                    snap_y_d   = sum_y_inc;
                    snap_cnt_d = cnt_inc;
                    state_d    = (cnt_inc >= CNT_W'(MIN_PIXELS)) ? ST_DIV_X : ST_PUBLISH;
                end
            end
            ST_DIV_X: begin
                if (div_bus.done) begin
                    xq_d    = div_bus.quotient;
                    state_d = ST_DIV_Y;
                end
            end
            ST_DIV_Y: begin
                if (div_bus.done) begin
                    yq_d    = div_bus.quotient;
                    state_d = ST_PUBLISH;
                end
            end
            ST_PUBLISH: begin
                pcnt_d  = snap_cnt_q;
                found_d = (snap_cnt_q >= CNT_W'(MIN_PIXELS));
                if (snap_cnt_q >= CNT_W'(MIN_PIXELS)) begin
                    cx_d = xq_q;
                    cy_d = yq_q;
                end
                rv_d    = 1'b1;
                state_d = ST_ACCUM;
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // All registered state, cleared by the synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_ACCUM;
            sum_x_q      <= '0;
            sum_y_q      <= '0;
            cnt_q        <= '0;
            snap_x_q     <= '0;
            snap_y_q     <= '0;
            snap_cnt_q   <= '0;
            xq_q         <= '0;
            yq_q         <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            pcnt_q       <= '0;
            found_q      <= 1'b0;
            rv_q         <= 1'b0;
            ovr_q        <= 1'b0;
            mask_q       <= 1'b0;
            mask_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sum_x_q      <= sum_x_d;
            sum_y_q      <= sum_y_d;
            cnt_q        <= cnt_d;
            snap_x_q     <= snap_x_d;
            snap_y_q     <= snap_y_d;
            snap_cnt_q   <= snap_cnt_d;
            xq_q         <= xq_d;
            yq_q         <= yq_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            pcnt_q       <= pcnt_d;
            found_q      <= found_d;
            rv_q         <= rv_d;
            ovr_q        <= ovr_d;
            mask_q       <= hit;
            mask_valid_q <= hue_valid;
        end
    end

    assign mask         = mask_q;
    assign mask_valid   = mask_valid_q;
    assign cx           = cx_q;
    assign cy           = cy_q;
    assign pixel_count  = pcnt_q;
    assign found        = found_q;
    assign result_valid = rv_q;
    assign overrun      = ovr_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_hsv_centroid.sv
// Directed and randomized bench for hsv_centroid with a frame-level reference model.
module tb_hsv_centroid;

    localparam int COORD_W    = 10;
    localparam int MIN_PIXELS = 64;
    localparam int SUM_MAX    = (1 << 30) - 1;
    localparam int CNT_MAX    = (1 << 19) - 1;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic [7:0]         h = '0, s = '0, v = '0;
    logic               hue_valid = 1'b0;
    logic [COORD_W-1:0] x = '0, y = '0;
    logic               frame_end = 1'b0;
    logic [7:0]         h_lo = '0, h_hi = '0, s_min = '0, v_min = '0;
    logic               mask, mask_valid, found, result_valid, overrun;
    logic [COORD_W-1:0] cx, cy;
    logic [18:0]        pixel_count;
    logic [1:0]         state_dbg;

    hsv_centroid #(.COORD_W(COORD_W), .MIN_PIXELS(MIN_PIXELS)) dut (
        .clock(clock), .reset(reset), .h(h), .s(s), .v(v), .hue_valid(hue_valid),
        .x(x), .y(y), .frame_end(frame_end), .h_lo(h_lo), .h_hi(h_hi),
        .s_min(s_min), .v_min(v_min), .mask(mask), .mask_valid(mask_valid),
        .cx(cx), .cy(cy), .pixel_count(pixel_count), .found(found),
        .result_valid(result_valid), .overrun(overrun), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: running frame totals and the last published centroid.
    longint m_sx = 0, m_sy = 0, m_cnt = 0;
    int     prev_cx = 0, prev_cy = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit hsv_match(input int ph, input int ps, input int pv);
        bit in_hue;
        if (h_lo <= h_hi) in_hue = (ph >= h_lo) && (ph <= h_hi);
        else              in_hue = (ph >= h_lo) || (ph <= h_hi);
        return in_hue && (ps >= s_min) && (pv >= v_min);
    endfunction

    function automatic void model_reset();
        m_sx = 0; m_sy = 0; m_cnt = 0;
        prev_cx = 0; prev_cy = 0;
    endfunction

    // One clock of input; the model adds a matched pixel and the mask is checked after the edge.
    task automatic drive(input bit hv, input int ph, input int ps, input int pv,
                         input int px, input int py, input bit fe);
        bit exp_m;
        @(negedge clock);
        hue_valid = hv;
        h = ph[7:0]; s = ps[7:0]; v = pv[7:0];
        x = px[COORD_W-1:0]; y = py[COORD_W-1:0];
        frame_end = fe;
        exp_m = hv && hsv_match(ph, ps, pv);
        if (exp_m) begin
            m_sx  = (m_sx + px > SUM_MAX) ? SUM_MAX : m_sx + px;
            m_sy  = (m_sy + py > SUM_MAX) ? SUM_MAX : m_sy + py;
            m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
        end
        @(posedge clock);
        #1;
        check("mask", mask, exp_m);
        check("mask_valid", mask_valid, hv);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 0, 0, 1'b0);
    endtask

    // Idles until result_valid, bounded; lat counts edges after the last driven edge.
    task automatic wait_result(output int lat, output bit seen_ovr);
        lat = 0;
        seen_ovr = 1'b0;
        while (lat < 200) begin
            @(negedge clock);
            hue_valid = 1'b0;
            frame_end = 1'b0;
            @(posedge clock);
            #1;
            lat++;
            if (overrun) seen_ovr = 1'b1;
            if (result_valid) break;
        end
    endtask

    task automatic check_result(input string tag, input int exp_lat, input longint sx,
                                input longint sy, input longint cnt);
        int lat;
        bit seen_ovr;
        bit exp_found;
        int exp_cx, exp_cy;
        exp_found = (cnt >= MIN_PIXELS);
        exp_cx = exp_found ? int'(sx / cnt) : prev_cx;
        exp_cy = exp_found ? int'(sy / cnt) : prev_cy;
        wait_result(lat, seen_ovr);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_count"}, pixel_count, cnt);
        check({tag, "_found"}, found, exp_found);
        check({tag, "_cx"}, cx, exp_cx);
        check({tag, "_cy"}, cy, exp_cy);
        check({tag, "_no_overrun"}, seen_ovr, 0);
        prev_cx = exp_cx;
        prev_cy = exp_cy;
        @(negedge clock);
        @(posedge clock);
        #1;
        check({tag, "_rv_pulse"}, result_valid, 0);
    endtask

    // Closes the frame (optionally with a pixel on the same cycle) and checks the published result.
    task automatic close_frame(input string tag, input bit hv, input int ph, input int ps,
                               input int pv, input int px, input int py);
        longint sx, sy, cnt;
        drive(hv, ph, ps, pv, px, py, 1'b1);
        sx = m_sx; sy = m_sy; cnt = m_cnt;
        m_sx = 0; m_sy = 0; m_cnt = 0;
        check_result(tag, (cnt >= MIN_PIXELS) ? 63 : 1, sx, sy, cnt);
    endtask

    task automatic set_window(input int lo, input int hi, input int smin, input int vmin);
        @(negedge clock);
        h_lo = lo[7:0]; h_hi = hi[7:0]; s_min = smin[7:0]; v_min = vmin[7:0];
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mask"}, mask, 0);
        check({tag, "_mask_valid"}, mask_valid, 0);
        check({tag, "_cx"}, cx, 0);
        check({tag, "_cy"}, cy, 0);
        check({tag, "_count"}, pixel_count, 0);
        check({tag, "_found"}, found, 0);
        check({tag, "_result_valid"}, result_valid, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        longint sx, sy, cnt;
        int n, seen_rv;

        // Reset state
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        check("reset_state", state_dbg, 0);
        @(negedge clock);
        reset = 1'b1;

        // Plain window, 100 identical matches
        set_window(40, 60, 50, 50);
        for (int i = 0; i < 100; i++) drive(1'b1, 50, 100, 100, 200, 100, 1'b0);
        close_frame("basic", 1'b0, 0, 0, 0, 0, 0);

        // Wrap-around hue window, then a small frame that must not report a target
        set_window(240, 10, 50, 50);
        drive(1'b1, 250, 200, 200, 17, 33, 1'b0);
        check("wrap_h250", mask, 1);
        drive(1'b1, 5, 200, 200, 17, 33, 1'b0);
        check("wrap_h5", mask, 1);
        drive(1'b1, 128, 200, 200, 17, 33, 1'b0);
        check("wrap_h128", mask, 0);
        drive(1'b1, 0, 49, 200, 1, 1, 1'b0);
        check("s_below_min", mask, 0);
        for (int i = 0; i < 8; i++)
            drive(1'b1, $urandom_range(240, 255), 50, 50,
                  $urandom_range(0, 1023), $urandom_range(0, 1023), 1'b0);
        close_frame("small", 1'b0, 0, 0, 0, 0, 0);
        check("small_count10", pixel_count, 10);

        // Pixel on the frame_end cycle counts; mean truncates
        set_window(40, 60, 50, 50);
        for (int i = 0; i < 63; i++) drive(1'b1, 45, 60, 60, 64, 10, 1'b0);
        close_frame("edge_pixel", 1'b1, 45, 60, 60, 0, 10);
        check("edge_cx63", cx, 63);

        // Randomized frames under random windows
        for (int f = 0; f < 4; f++) begin
            set_window($urandom_range(0, 255), $urandom_range(0, 255),
                       $urandom_range(0, 100), $urandom_range(0, 100));
            n = $urandom_range(60, 250);
            for (int i = 0; i < n; i++)
                drive($urandom_range(0, 9) != 0, $urandom_range(0, 255), $urandom_range(0, 255),
                      $urandom_range(0, 255), $urandom_range(0, 1023), $urandom_range(0, 1023), 1'b0);
            close_frame($sformatf("rand%0d", f), 1'b1, $urandom_range(0, 255),
                        $urandom_range(0, 255), $urandom_range(0, 255),
                        $urandom_range(0, 1023), $urandom_range(0, 1023));
        end

        // Second frame_end during the divide: overrun, first result intact, next frame from zero
        set_window(40, 60, 50, 50);
        for (int i = 0; i < 70; i++) drive(1'b1, 50, 100, 100, 300, 50, 1'b0);
        drive(1'b0, 0, 0, 0, 0, 0, 1'b1);
        sx = m_sx; sy = m_sy; cnt = m_cnt;
        m_sx = 0; m_sy = 0; m_cnt = 0;
        for (int i = 0; i < 19; i++) drive(1'b1, 50, 100, 100, $urandom_range(0, 1023), 7, 1'b0);
        drive(1'b1, 50, 100, 100, 900, 900, 1'b1);
        check("overrun_pulse", overrun, 1);
        m_sx = 0; m_sy = 0; m_cnt = 0;
        check_result("overrun_first", 43, sx, sy, cnt);
        for (int i = 0; i < 66; i++) drive(1'b1, 55, 100, 100, 10, 20, 1'b0);
        close_frame("after_overrun", 1'b0, 0, 0, 0, 0, 0);

        // Reset in the middle of DIV_X aborts the divide
        for (int i = 0; i < 70; i++) drive(1'b1, 50, 100, 100, 500, 500, 1'b0);
        drive(1'b0, 0, 0, 0, 0, 0, 1'b1);
        idle_cycles(30);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("mid_div_reset");
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        seen_rv = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clock);
            #1;
            if (result_valid) seen_rv++;
        end
        check("no_result_after_reset", seen_rv, 0);
        for (int i = 0; i < 80; i++) drive(1'b1, 50, 100, 100, 5, 7, 1'b0);
        close_frame("post_reset", 1'b0, 0, 0, 0, 0, 0);
        check("post_reset_count80", pixel_count, 80);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
